// File: rtl/pio_input_conditioner_if.sv
// Bundle of the PIO-facing signals of the input conditioner: raw board
// inputs and host clear in, registered export words and press pulses out.
interface pio_input_conditioner_if #(
    parameter int N_BTN = 4,
    parameter int N_SW  = 18
);
    logic [N_BTN-1:0] key_n;
    logic [N_SW-1:0]  sw;
    logic [N_BTN-1:0] evt_clr;
    logic [31:0]      buttons_export;
    logic [31:0]      switchs_export;
    logic [N_BTN-1:0] btn_press_pulse;

    // Board/host side: drives raw inputs and clears, observes exports
    modport master (
        output key_n,
        output sw,
        output evt_clr,
        input  buttons_export,
        input  switchs_export,
        input  btn_press_pulse
    );

    // Conditioner side
    modport slave (
        input  key_n,
        input  sw,
        input  evt_clr,
        output buttons_export,
        output switchs_export,
        output btn_press_pulse
    );
endinterface

// File: rtl/pio_input_conditioner.sv
// Conditions raw push-buttons (active-low) and slide switches before they
// reach the PIO export inputs: 2-FF synchronizer, counter debouncer per bit,
// plus a registered press pulse and a host-clearable sticky press flag.
// Buttons and switches share one debounce vector: bits [N_BTN-1:0] are the
// buttons (already inverted to active-high), the rest are the switches.
module pio_input_conditioner #(
    parameter int N_BTN           = 4,
    parameter int N_SW            = 18,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic                    clk,
    input  logic                    reset,
    pio_input_conditioner_if.slave  bus
);
    localparam int N_IN = N_BTN + N_SW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] key_s1_q, key_s1_d, key_s2_q, key_s2_d;
    logic [N_SW-1:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [N_IN-1:0]  level;
    logic [N_IN-1:0]  stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [N_IN];
    logic [CNT_W-1:0] cnt_d [N_IN];
    logic [N_BTN-1:0] pulse_q, pulse_d;
    logic [N_BTN-1:0] evt_q, evt_d;

    // Synchronizer shift: first stage captures the raw pin, second re-times it
    always_comb begin
        key_s1_d = bus.key_n;
        key_s2_d = key_s1_q;
        sw_s1_d  = bus.sw;
        sw_s2_d  = sw_s1_q;
    end

    // Debounce: a new level must persist DEBOUNCE_CYCLES checks before it is
    // accepted; any return to the stable level restarts the count, so the
    // counter never reaches past CNT_LAST and cannot wrap
    always_comb begin
        level    = {sw_s2_q, ~key_s2_q};
        stable_d = stable_q;
        for (int i = 0; i < N_IN; i++) begin
            cnt_d[i] = '0;
            if (level[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = level[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Press pulse fires on the same edge a button's stable level rises; a
    // simultaneous press beats a host clear so no event is ever lost
    always_comb begin
        pulse_d = stable_d[N_BTN-1:0] & ~stable_q[N_BTN-1:0];
        evt_d   = (evt_q & ~bus.evt_clr) | pulse_d;
    end

    // State registers; key synchronizers reset to released (1)
    always_ff @(posedge clk) begin
        if (reset) begin
            key_s1_q <= '1;
            key_s2_q <= '1;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            stable_q <= '0;
            pulse_q  <= '0;
            evt_q    <= '0;
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            key_s1_q <= key_s1_d;
            key_s2_q <= key_s2_d;
            sw_s1_q  <= sw_s1_d;
            sw_s2_q  <= sw_s2_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            evt_q    <= evt_d;
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Export words are pure flop outputs placed at their PIO bit positions
    always_comb begin
        bus.buttons_export                   = '0;
        bus.buttons_export[N_BTN-1:0]        = stable_q[N_BTN-1:0];
        bus.buttons_export[16 +: N_BTN]      = evt_q;
        bus.switchs_export                   = '0;
        bus.switchs_export[N_SW-1:0]         = stable_q[N_IN-1:N_BTN];
        bus.btn_press_pulse                  = pulse_q;
    end
endmodule

// File: tb/tb_pio_input_conditioner.sv
// Directed bench for pio_input_conditioner with a short debounce window.
// Each vector holds its inputs for a number of cycles and checks the
// hand-computed outputs #1 after every rising edge.
module tb_pio_input_conditioner;
    localparam int N_BTN = 4;
    localparam int N_SW  = 18;
    localparam int DB    = 4;
    localparam int CW    = 3;

    logic clk;
    logic reset;
    int   assertCount;
    int   failCount;

    pio_input_conditioner_if #(.N_BTN(N_BTN), .N_SW(N_SW)) bus ();

    pio_input_conditioner #(
        .N_BTN(N_BTN),
        .N_SW(N_SW),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic [3:0]  key_n;
        logic [17:0] sw;
        logic [3:0]  clr;
        int          cycles;
        logic [31:0] exp_btn;
        logic [31:0] exp_sw;
        logic [3:0]  exp_pulse;
    } vec_t;

    vec_t vecs[13];

    // Compares all three outputs against the expected values
    task automatic checkOutput(input string name, input logic [31:0] eb,
                               input logic [31:0] es, input logic [3:0] ep);
        assertCount++;
        if (bus.buttons_export !== eb) begin
            failCount++;
            $display("[TB] FAIL %s buttons_export got %h expected %h", name, bus.buttons_export, eb);
        end
        assertCount++;
        if (bus.switchs_export !== es) begin
            failCount++;
            $display("[TB] FAIL %s switchs_export got %h expected %h", name, bus.switchs_export, es);
        end
        assertCount++;
        if (bus.btn_press_pulse !== ep) begin
            failCount++;
            $display("[TB] FAIL %s btn_press_pulse got %h expected %h", name, bus.btn_press_pulse, ep);
        end
    endtask

    // Holds inputs for n edges, checking the outputs after each edge
    task automatic applyStimulus(input logic r, input logic [3:0] k, input logic [17:0] s,
                                 input logic [3:0] c, input int n, input logic [31:0] eb,
                                 input logic [31:0] es, input logic [3:0] ep, input string name);
        reset       = r;
        bus.key_n   = k;
        bus.sw      = s;
        bus.evt_clr = c;
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("%s[%0d]", name, j), eb, es, ep);
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        reset       = 1'b1;
        bus.key_n   = 4'hF;
        bus.sw      = '0;
        bus.evt_clr = '0;

        // Reset with all buttons pressed and all switches on, then acceptance,
        // clear, release, clean press of button 1, release + new switch word
        vecs[0]  = '{1'b1, 4'h0, 18'h3FFFF, 4'h0, 3, 32'h0000_0000, 32'h0000_0000, 4'h0};
        vecs[1]  = '{1'b0, 4'h0, 18'h3FFFF, 4'h0, 5, 32'h0000_0000, 32'h0000_0000, 4'h0};
        vecs[2]  = '{1'b0, 4'h0, 18'h3FFFF, 4'h0, 1, 32'h000F_000F, 32'h0003_FFFF, 4'hF};
        vecs[3]  = '{1'b0, 4'h0, 18'h3FFFF, 4'h0, 1, 32'h000F_000F, 32'h0003_FFFF, 4'h0};
        vecs[4]  = '{1'b0, 4'h0, 18'h3FFFF, 4'hF, 1, 32'h0000_000F, 32'h0003_FFFF, 4'h0};
        vecs[5]  = '{1'b0, 4'hF, 18'h3FFFF, 4'h0, 5, 32'h0000_000F, 32'h0003_FFFF, 4'h0};
        vecs[6]  = '{1'b0, 4'hF, 18'h3FFFF, 4'h0, 1, 32'h0000_0000, 32'h0003_FFFF, 4'h0};
        vecs[7]  = '{1'b0, 4'hD, 18'h3FFFF, 4'h0, 5, 32'h0000_0000, 32'h0003_FFFF, 4'h0};
        vecs[8]  = '{1'b0, 4'hD, 18'h3FFFF, 4'h0, 1, 32'h0002_0002, 32'h0003_FFFF, 4'h2};
        vecs[9]  = '{1'b0, 4'hD, 18'h3FFFF, 4'h0, 1, 32'h0002_0002, 32'h0003_FFFF, 4'h0};
        vecs[10] = '{1'b0, 4'hF, 18'h2A5A5, 4'h0, 5, 32'h0002_0002, 32'h0003_FFFF, 4'h0};
        vecs[11] = '{1'b0, 4'hF, 18'h2A5A5, 4'h0, 1, 32'h0002_0000, 32'h0002_A5A5, 4'h0};
        vecs[12] = '{1'b0, 4'hF, 18'h2A5A5, 4'h0, 2, 32'h0002_0000, 32'h0002_A5A5, 4'h0};

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].key_n, vecs[i].sw, vecs[i].clr, vecs[i].cycles,
                          vecs[i].exp_btn, vecs[i].exp_sw, vecs[i].exp_pulse,
                          $sformatf("vec%0d", i));
        end

        // Bounce on button 0: low 3, high 1, low 2, then high; never accepted
        applyStimulus(1'b0, 4'hE, 18'h2A5A5, 4'h0, 3, 32'h0002_0000, 32'h0002_A5A5, 4'h0, "bounce_lo1");
        applyStimulus(1'b0, 4'hF, 18'h2A5A5, 4'h0, 1, 32'h0002_0000, 32'h0002_A5A5, 4'h0, "bounce_hi1");
        applyStimulus(1'b0, 4'hE, 18'h2A5A5, 4'h0, 2, 32'h0002_0000, 32'h0002_A5A5, 4'h0, "bounce_lo2");
        applyStimulus(1'b0, 4'hF, 18'h2A5A5, 4'h0, 8, 32'h0002_0000, 32'h0002_A5A5, 4'h0, "bounce_hi2");

        // Button 2: first press sets evt[2], release, second press collides with clear
        applyStimulus(1'b0, 4'hB, 18'h2A5A5, 4'h0, 5, 32'h0002_0000, 32'h0002_A5A5, 4'h0, "b2_press_wait");
        applyStimulus(1'b0, 4'hB, 18'h2A5A5, 4'h0, 1, 32'h0006_0004, 32'h0002_A5A5, 4'h4, "b2_press");
        applyStimulus(1'b0, 4'hF, 18'h2A5A5, 4'h0, 5, 32'h0006_0004, 32'h0002_A5A5, 4'h0, "b2_rel_wait");
        applyStimulus(1'b0, 4'hF, 18'h2A5A5, 4'h0, 1, 32'h0006_0000, 32'h0002_A5A5, 4'h0, "b2_rel");
        applyStimulus(1'b0, 4'hB, 18'h2A5A5, 4'h0, 5, 32'h0006_0000, 32'h0002_A5A5, 4'h0, "b2_repress_wait");
        applyStimulus(1'b0, 4'hB, 18'h2A5A5, 4'h4, 1, 32'h0006_0004, 32'h0002_A5A5, 4'h4, "clr_vs_press");
        applyStimulus(1'b0, 4'hB, 18'h2A5A5, 4'h4, 1, 32'h0002_0004, 32'h0002_A5A5, 4'h0, "clr_alone");

        // Switch change interrupted by reset two edges in; full latency restarts
        applyStimulus(1'b0, 4'hF, 18'h3FFFF, 4'h0, 2, 32'h0002_0004, 32'h0002_A5A5, 4'h0, "mid_pre");
        applyStimulus(1'b1, 4'hF, 18'h3FFFF, 4'h0, 1, 32'h0000_0000, 32'h0000_0000, 4'h0, "mid_reset");
        applyStimulus(1'b0, 4'hF, 18'h3FFFF, 4'h0, 5, 32'h0000_0000, 32'h0000_0000, 4'h0, "mid_wait");
        applyStimulus(1'b0, 4'hF, 18'h3FFFF, 4'h0, 1, 32'h0000_0000, 32'h0003_FFFF, 4'h0, "mid_accept");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
